// File: rtl/ascon_serial_pkg.sv
// Shared types and sizing helpers for the Ascon bit-serial pin front-end.
package ascon_serial_pkg;

  localparam int unsigned NONCE_W = 128;
  localparam int unsigned TAG_W   = 128;

  typedef enum logic [2:0] {SHIFT, LOADED, BUSY, WAIT, TX} state_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Serial load/transmit length: longest of the fields, never shorter than nonce/tag.
  function automatic int unsigned cntMax(int unsigned k, int unsigned l, int unsigned y);
    return max3(max3(k, l, y), NONCE_W, TAG_W);
  endfunction

endpackage

// File: rtl/ascon_piso.sv
// Parallel-in/serial-out register for ciphertext and tag, LSB first, zero fill.
module ascon_piso
  import ascon_serial_pkg::*;
#(
  parameter int unsigned Y = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [Y-1:0]     ct_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             ctBit,
  output logic             tagBit
);

  logic [Y-1:0]     ctReg;
  logic [TAG_W-1:0] tagReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctReg  <= '0;
      tagReg <= '0;
    end else if (load) begin
      ctReg  <= ct_i;
      tagReg <= tag_i;
    end else if (shift) begin
      ctReg  <= ctReg >> 1;
      tagReg <= tagReg >> 1;
    end
  end

  assign ctBit  = ctReg[0];
  assign tagBit = tagReg[0];

endmodule

// File: rtl/ascon_serial_if.sv
// Bit-serial pin front-end for the Ascon core: serial load, start handshake, serial result.
// Optional macro ASCON_SERIAL_RND_EN registers the per-pin randomness bits into rnd_o.
module ascon_serial_if
  import ascon_serial_pkg::*;
#(
  parameter int unsigned K        = 128,
  parameter int unsigned L        = 40,
  parameter int unsigned Y        = 40,
  parameter int unsigned TX_DELAY = 2    // must be >= 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         keyxSI,
  input  logic [2:0]         noncexSI,
  input  logic [2:0]         associated_dataxSI,
  input  logic [2:0]         plain_textxSI,
  input  logic               encryption_startxSI,
  output logic [K-1:0]       key_o,
  output logic [NONCE_W-1:0] nonce_o,
  output logic [L-1:0]       ad_o,
  output logic [Y-1:0]       pt_o,
  output logic [7:0]         rnd_o,
  output logic               start_o,
  input  logic               done_i,
  input  logic [Y-1:0]       ct_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               cipher_textxSO,
  output logic               tagxSO,
  output logic               encryption_readyxSO
);

  localparam int unsigned CNT_MAX = cntMax(K, L, Y);
  localparam int unsigned CNT_W   = $clog2(max3(CNT_MAX, TX_DELAY, 1) + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TX_DELAY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pisoLoad, pisoShift, pisoCt, pisoTag;

  // A done strobe coinciding with the start pulse predates the core run and is dropped.
  assign pisoLoad  = (state == BUSY) && done_i && !start_o;
  assign pisoShift = ((state == WAIT) && (cnt == WAIT_LAST)) ||
                     ((state == TX) && (cnt != CNT_LAST));

  ascon_piso #(.Y(Y)) uPiso (
    .clk    (clk),
    .rst    (rst),
    .load   (pisoLoad),
    .shift  (pisoShift),
    .ct_i   (ct_i),
    .tag_i  (tag_i),
    .ctBit  (pisoCt),
    .tagBit (pisoTag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= SHIFT;
      cnt                 <= '0;
      key_o               <= '0;
      nonce_o             <= '0;
      ad_o                <= '0;
      pt_o                <= '0;
      start_o             <= 1'b0;
      encryption_readyxSO <= 1'b0;
      cipher_textxSO      <= 1'b0;
      tagxSO              <= 1'b0;
    end else begin
      start_o <= 1'b0;
      case (state)
        SHIFT: begin
          // MSB-first capture; indices past a field's width never match.
          for (int unsigned b = 0; b < K; b++)
            if (cnt == CNT_W'(K - 1 - b)) key_o[b] <= keyxSI[0];
          for (int unsigned b = 0; b < NONCE_W; b++)
            if (cnt == CNT_W'(NONCE_W - 1 - b)) nonce_o[b] <= noncexSI[0];
          for (int unsigned b = 0; b < L; b++)
            if (cnt == CNT_W'(L - 1 - b)) ad_o[b] <= associated_dataxSI[0];
          for (int unsigned b = 0; b < Y; b++)
            if (cnt == CNT_W'(Y - 1 - b)) pt_o[b] <= plain_textxSI[0];
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= LOADED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOADED: begin
          if (encryption_startxSI) begin
            start_o <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (pisoLoad) begin
            encryption_readyxSO <= 1'b1;
            cnt                 <= '0;
            state               <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt            <= '0;
            cipher_textxSO <= pisoCt;
            tagxSO         <= pisoTag;
            state          <= TX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX: begin
          if (cnt == CNT_LAST) begin
            cnt                 <= '0;
            encryption_readyxSO <= 1'b0;
            cipher_textxSO      <= 1'b0;
            tagxSO              <= 1'b0;
            state               <= SHIFT;
          end else begin
            cnt            <= cnt + 1'b1;
            cipher_textxSO <= pisoCt;
            tagxSO         <= pisoTag;
          end
        end
        default: state <= SHIFT;
      endcase
    end
  end

`ifdef ASCON_SERIAL_RND_EN
  always_ff @(posedge clk) begin
    if (rst) rnd_o <= '0;
    else     rnd_o <= {keyxSI[2:1], associated_dataxSI[2:1], plain_textxSI[2:1], noncexSI[2:1]};
  end
`else
  logic unusedRnd;
  assign unusedRnd = ^{keyxSI[2:1], associated_dataxSI[2:1], plain_textxSI[2:1], noncexSI[2:1]};
  assign rnd_o     = '0;
`endif

endmodule
